// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: byte-frame command decoder driving RF writes/reads and ALU runs, returning results LSB first to the TX FIFO.
//  Ports: CLK/RST (async, active-low); Sync_Frame/enable_pulse received bytes;
//  Rd_D/Rd_D_Valid, Rd_En/Wr_En/Addr/Wr_D register file; ALU_OUT/OUT_Valid, ALU_En/FUN/Gate_En ALU;
//  FIFO_FULL, WR_INC/WR_DATA TX FIFO push; Frame_Err pulse on bad command, timeout or dropped byte.
module cmd_frame_ctrl #(
  parameter int D_WIDTH     = 8,
  parameter int ADDR_SIZE   = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [D_WIDTH-1:0]     Sync_Frame,
  input  logic                   enable_pulse,
  input  logic [D_WIDTH-1:0]     Rd_D,
  input  logic                   Rd_D_Valid,
  output logic                   Rd_En,
  output logic                   Wr_En,
  output logic [ADDR_SIZE-1:0]   Addr,
  output logic [D_WIDTH-1:0]     Wr_D,
  input  logic [2*D_WIDTH-1:0]   ALU_OUT,
  input  logic                   OUT_Valid,
  output logic                   ALU_En,
  output logic [FUN_WIDTH-1:0]   FUN,
  output logic                   Gate_En,
  input  logic                   FIFO_FULL,
  output logic                   WR_INC,
  output logic [D_WIDTH-1:0]     WR_DATA,
  output logic                   Frame_Err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [D_WIDTH-1:0] C_WR = D_WIDTH'(8'hAA);
  localparam logic [D_WIDTH-1:0] C_RD = D_WIDTH'(8'hBB);
  localparam logic [D_WIDTH-1:0] C_AB = D_WIDTH'(8'hCC);
  localparam logic [D_WIDTH-1:0] C_AF = D_WIDTH'(8'hDD);
  localparam logic [D_WIDTH-1:0] C_BW = D_WIDTH'(8'hEE);
  localparam logic [D_WIDTH-1:0] C_BR = D_WIDTH'(8'hEF);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_CNT, GET_DATA, RD_REQ, RD_WAIT, GET_A, GET_B,
    GET_FUN, ALU_RUN, ALU_WAIT, PUSH_LO, PUSH_HI
  } state_t;

  state_t                 state, state_nx;
  logic [D_WIDTH-1:0]     cmd, cmd_nx, cnt, cnt_nx, wr_d_nx;
  logic [ADDR_SIZE-1:0]   addr_nx;
  logic [FUN_WIDTH-1:0]   fun_nx;
  logic [2*D_WIDTH-1:0]   res, res_nx;
  logic [TW-1:0]          tmr, tmr_nx;
  logic                   wr_en_nx, err_nx, byte_wait, counting, burst, timed_out;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cmd       <= '0;
      cnt       <= '0;
      Addr      <= '0;
      Wr_D      <= '0;
      Wr_En     <= 1'b0;
      FUN       <= '0;
      res       <= '0;
      tmr       <= '0;
      ALU_En    <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd       <= cmd_nx;
      cnt       <= cnt_nx;
      Addr      <= addr_nx;
      Wr_D      <= wr_d_nx;
      Wr_En     <= wr_en_nx;
      FUN       <= fun_nx;
      res       <= res_nx;
      tmr       <= tmr_nx;
      ALU_En    <= state == ALU_RUN;
      Frame_Err <= err_nx;
    end
  end

  always_comb begin
    byte_wait = state inside {GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN};
    counting  = byte_wait || state == RD_WAIT || state == ALU_WAIT;
    burst     = cmd == C_BW || cmd == C_BR;
    timed_out = tmr == TW'(TIMEOUT_CYC);
    state_nx  = state;
    cmd_nx    = cmd;
    cnt_nx    = cnt;
    // Burst writes advance the address in the cycle the write strobe is out,
    // so Addr stays valid alongside Wr_En.
    addr_nx   = (Wr_En && burst) ? Addr + ADDR_SIZE'(1) : Addr;
    wr_d_nx   = Wr_D;
    fun_nx    = FUN;
    res_nx    = res;
    wr_en_nx  = 1'b0;
    err_nx    = enable_pulse && !byte_wait && state != IDLE;
    case (state)
      IDLE: if (enable_pulse) begin
        cmd_nx = Sync_Frame;
        if (Sync_Frame inside {C_WR, C_RD, C_BW, C_BR}) state_nx = GET_ADDR;
        else if (Sync_Frame == C_AB) state_nx = GET_A;
        else if (Sync_Frame == C_AF) state_nx = GET_FUN;
        else err_nx = 1'b1;
      end
      GET_ADDR: if (enable_pulse) begin
        addr_nx  = Sync_Frame[ADDR_SIZE-1:0];
        state_nx = cmd == C_WR ? GET_DATA : cmd == C_RD ? RD_REQ : GET_CNT;
      end
      GET_CNT: if (enable_pulse) begin
        cnt_nx   = Sync_Frame;
        state_nx = Sync_Frame == '0 ? IDLE : cmd == C_BW ? GET_DATA : RD_REQ;
      end
      GET_DATA: if (enable_pulse) begin
        wr_en_nx = 1'b1;
        wr_d_nx  = Sync_Frame;
        cnt_nx   = cnt - D_WIDTH'(1);
        state_nx = (cmd == C_WR || cnt == D_WIDTH'(1)) ? IDLE : GET_DATA;
      end
      GET_A: if (enable_pulse) begin
        wr_en_nx = 1'b1;
        wr_d_nx  = Sync_Frame;
        addr_nx  = '0;
        state_nx = GET_B;
      end
      GET_B: if (enable_pulse) begin
        wr_en_nx = 1'b1;
        wr_d_nx  = Sync_Frame;
        addr_nx  = ADDR_SIZE'(1);
        state_nx = GET_FUN;
      end
      GET_FUN: if (enable_pulse) begin
        fun_nx   = Sync_Frame[FUN_WIDTH-1:0];
        state_nx = ALU_RUN;
      end
      RD_REQ: state_nx = RD_WAIT;
      RD_WAIT: if (Rd_D_Valid) begin
        res_nx   = (2*D_WIDTH)'(Rd_D);
        addr_nx  = burst ? Addr + ADDR_SIZE'(1) : Addr;
        state_nx = PUSH_LO;
      end
      ALU_RUN: state_nx = ALU_WAIT;
      ALU_WAIT: if (OUT_Valid) begin
        res_nx   = ALU_OUT;
        state_nx = PUSH_LO;
      end
      PUSH_LO: if (!FIFO_FULL) begin
        cnt_nx   = cmd == C_BR ? cnt - D_WIDTH'(1) : cnt;
        state_nx = (cmd == C_AB || cmd == C_AF) ? PUSH_HI :
                   (cmd == C_BR && cnt != D_WIDTH'(1)) ? RD_REQ : IDLE;
      end
      PUSH_HI: if (!FIFO_FULL) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timed_out && ((byte_wait && !enable_pulse) || (state == RD_WAIT && !Rd_D_Valid) ||
                      (state == ALU_WAIT && !OUT_Valid))) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end
    tmr_nx = (enable_pulse || state_nx != state) ? '0 : counting ? tmr + TW'(1) : tmr;
  end

  assign Rd_En   = state == RD_REQ;
  assign Gate_En = state == ALU_RUN || state == ALU_WAIT;
  assign WR_INC  = (state == PUSH_LO || state == PUSH_HI) && !FIFO_FULL;
  assign WR_DATA = state == PUSH_HI ? res[2*D_WIDTH-1:D_WIDTH] : res[D_WIDTH-1:0];
endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// tb_cmd_frame_ctrl: scoreboard bench for cmd_frame_ctrl with RF and ALU behavioural models.
module tb_cmd_frame_ctrl;
  logic        CLK = 0, RST = 0;
  logic [7:0]  Sync_Frame = 0, Rd_D = 0;
  logic        enable_pulse = 0, Rd_D_Valid = 0, OUT_Valid = 0, FIFO_FULL = 0;
  logic [15:0] ALU_OUT = 0;
  logic        Rd_En, Wr_En, ALU_En, Gate_En, WR_INC, Frame_Err;
  logic [3:0]  Addr, FUN;
  logic [7:0]  Wr_D, WR_DATA;

  cmd_frame_ctrl dut (
    .CLK(CLK), .RST(RST), .Sync_Frame(Sync_Frame), .enable_pulse(enable_pulse),
    .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid), .Rd_En(Rd_En), .Wr_En(Wr_En), .Addr(Addr),
    .Wr_D(Wr_D), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .ALU_En(ALU_En), .FUN(FUN),
    .Gate_En(Gate_En), .FIFO_FULL(FIFO_FULL), .WR_INC(WR_INC), .WR_DATA(WR_DATA),
    .Frame_Err(Frame_Err)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int n_rd = 0, n_alu = 0, n_err = 0, n_push = 0;
  logic [7:0]  push_q[$];
  logic [11:0] wr_q[$];
  logic [7:0]  rf [16];
  logic [15:0] alu_res = 0;
  logic        prev_gate = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (WR_INC) begin
        n_push++;
        chk("push_while_full", FIFO_FULL, 0);
        if (push_q.size() == 0) chk("push_unexpected", {24'h0, WR_DATA}, 32'hFFFF);
        else chk("push_data", WR_DATA, push_q.pop_front());
      end
      if (Wr_En) begin
        rf[Addr] = Wr_D;
        if (wr_q.size() == 0) chk("wr_unexpected", {Addr, Wr_D}, 32'hFFFF);
        else chk("wr_addr_data", {Addr, Wr_D}, wr_q.pop_front());
      end
      if (ALU_En) begin
        n_alu++;
        chk("gate_before_alu_en", {prev_gate, Gate_En}, 2'b11);
      end
      if (Rd_En) n_rd++;
      if (Frame_Err) n_err++;
    end
    prev_gate = Gate_En;
  end

  always begin
    @(negedge CLK);
    if (Rd_En) begin
      repeat (2) @(negedge CLK);
      Rd_D = rf[Addr];
      Rd_D_Valid = 1;
      @(negedge CLK);
      Rd_D_Valid = 0;
    end
  end

  always begin
    @(negedge CLK);
    if (ALU_En) begin
      repeat (3) @(negedge CLK);
      ALU_OUT = alu_res;
      OUT_Valid = 1;
      @(negedge CLK);
      OUT_Valid = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge CLK);
    #1 Sync_Frame = b;
    enable_pulse = 1;
    @(posedge CLK);
    #1 enable_pulse = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr;
    n_rd = 0; n_alu = 0; n_err = 0; n_push = 0;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_wr_pending"}, wr_q.size(), 0);
    chk({tag, "_push_pending"}, push_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 0;
    idle(2);
    chk("reset_outputs", {Rd_En, Wr_En, ALU_En, Gate_En, WR_INC, Frame_Err, Addr, FUN, Wr_D, WR_DATA}, 0);
    #2 RST = 1;
    idle(2);
    chk("post_reset_idle", {Rd_En, Wr_En, ALU_En, Gate_En, WR_INC, Frame_Err}, 0);

    clr; wr_q.push_back({4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C); idle(10);
    drained("t1"); chk("t1_err", n_err, 0); chk("t1_push", n_push, 0);

    clr; push_q.push_back(8'h3C);
    send(8'hBB); send(8'h05); idle(12);
    drained("t2"); chk("t2_rd_en", n_rd, 1); chk("t2_push", n_push, 1);

    clr; alu_res = 16'h000A;
    wr_q.push_back({4'h0, 8'h07}); wr_q.push_back({4'h1, 8'h03});
    push_q.push_back(8'h0A); push_q.push_back(8'h00);
    send(8'hCC); send(8'h07); send(8'h03); send(8'h00); idle(15);
    drained("t3"); chk("t3_alu_en", n_alu, 1); chk("t3_gate_low", Gate_En, 0);
    chk("t3_fun", FUN, 0); chk("t3_err", n_err, 0);

    clr; alu_res = 16'hBEEF;
    push_q.push_back(8'hEF); push_q.push_back(8'hBE);
    send(8'hDD); send(8'h05); idle(15);
    drained("dd"); chk("dd_fun", FUN, 5); chk("dd_alu_en", n_alu, 1);

    clr;
    wr_q.push_back({4'hE, 8'h11}); wr_q.push_back({4'hF, 8'h22}); wr_q.push_back({4'h0, 8'h33});
    send(8'hEE); send(8'h0E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); idle(8);
    drained("t4w");
    push_q.push_back(8'h11); push_q.push_back(8'h22); push_q.push_back(8'h33);
    send(8'hEF); send(8'h0E); send(8'h03); idle(30);
    drained("t4r"); chk("t4_rd_en", n_rd, 3); chk("t4_err", n_err, 0);

    clr;
    send(8'hEE); send(8'h03); send(8'h00); idle(8);
    chk("n0_no_write", wr_q.size(), 0); chk("n0_err", n_err, 0);
    wr_q.push_back({4'h9, 8'h66});
    send(8'hAA); send(8'h09); send(8'h66); idle(6);
    drained("n0_next");

    clr; FIFO_FULL = 1; push_q.push_back(8'h3C);
    send(8'hBB); send(8'h05); idle(50);
    chk("t5_stalled", n_push, 0); chk("t5_err", n_err, 0);
    send(8'h55); idle(3);
    chk("t5_drop_err", n_err, 1);
    FIFO_FULL = 0; idle(5);
    chk("t5_push_once", n_push, 1); drained("t5");

    clr;
    send(8'hAA); send(8'h05); idle(4000);
    chk("t6_no_early_err", n_err, 0);
    idle(200);
    chk("t6_timeout_err", n_err, 1);
    wr_q.push_back({4'h7, 8'h5A});
    send(8'hAA); send(8'h07); send(8'h5A); idle(6);
    drained("t6_next"); chk("t6_next_err", n_err, 1);
    send(8'h12); idle(4);
    chk("t6_bad_cmd_err", n_err, 2);

    clr; wr_q.push_back({4'h3, 8'h44});
    send(8'hAA); send(8'h03);
    #3 RST = 0; idle(2);
    chk("async_reset", {Gate_En, Wr_En, Addr}, 0);
    RST = 1; wr_q.delete();
    send(8'h44); idle(4);
    chk("reset_discards_frame", n_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
